// File: rtl/huc6270_pkg.sv
// Shared definitions for the HuC6270 VDC model: register selects, CPU port states
// and the address auto-increment decode.
package huc6270_pkg;

    localparam logic [4:0] AR_MAWR  = 5'h00;
    localparam logic [4:0] AR_MARR  = 5'h01;
    localparam logic [4:0] AR_VDATA = 5'h02;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_PEND  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } port_state_t;

    function automatic logic [15:0] vdc_incr(input logic [1:0] sel);
        logic [15:0] step;
        case (sel)
            2'b00:   step = 16'd1;
            2'b01:   step = 16'd32;
            2'b10:   step = 16'd64;
            default: step = 16'd128;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/vdc_vram_cpu_port.sv
// CPU-side VRAM initiator: MAWR/MARR/VWR/VRR registers with auto-increment and a
// one-word read-ahead, issuing VRAM cycles only in slots granted by the arbiter.
//
// state    | meaning
// IDLE     | no access outstanding, triggers accepted
// WR_PEND  | VWR word buffered, waiting for a slot to write at mawr
// RD_ISSUE | fetch of marr waiting for a slot
// RD_WAIT  | read issued, VRAM data arrives at the next edge into vrr
module vdc_vram_cpu_port
    import huc6270_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic [4:0]        ar,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_hi,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic [1:0]        incr_sel,
    input  logic              slot_grant,
    output logic [ADDR_W-1:0] vram_MA,
    output logic              vram_re,
    output logic              vram_we,
    output logic [15:0]       vram_wdata,
    input  logic [15:0]       vram_rdata,
    output logic              busy,
    output logic              overrun
);

    port_state_t       state, state_nxt;
    logic [ADDR_W-1:0] mawr, marr, ma_last, inc;
    logic [15:0]       vrr, wbuf, wdata_last;
    logic [7:0]        wlo, alo;

    logic wr_hi, wr_lo, rd_hi, idle;
    logic trig_mawr, trig_marr, trig_vwr, trig_vrr, trig_any, accept;

    assign inc = ADDR_W'(vdc_incr(incr_sel));

    // A simultaneous write strobe masks the read strobe.
    assign wr_hi = cpu_wr & cpu_hi;
    assign wr_lo = cpu_wr & ~cpu_hi;
    assign rd_hi = ~cpu_wr & cpu_rd & cpu_hi;

    assign trig_mawr = wr_hi & (ar == AR_MAWR);
    assign trig_marr = wr_hi & (ar == AR_MARR);
    assign trig_vwr  = wr_hi & (ar == AR_VDATA);
    assign trig_vrr  = rd_hi & (ar == AR_VDATA);
    assign trig_any  = trig_mawr | trig_marr | trig_vwr | trig_vrr;

    assign idle    = (state == IDLE);
    assign busy    = ~idle;
    assign accept  = trig_any & idle;
    assign overrun = trig_any & ~idle;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vram_re   = 1'b0;
        vram_we   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && trig_vwr) begin
                    state_nxt = WR_PEND;
                end else if (accept && (trig_marr || trig_vrr)) begin
                    state_nxt = RD_ISSUE;
                end
            end
            WR_PEND: begin
                if (slot_grant) begin
                    vram_we   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                if (slot_grant) begin
                    vram_re   = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus shows the pending address while waiting for a slot, the last one otherwise.
    assign vram_MA    = (state == WR_PEND)  ? mawr :
                        (state == RD_ISSUE) ? marr : ma_last;
    assign vram_wdata = (state == WR_PEND)  ? wbuf : wdata_last;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            mawr       <= '0;
            marr       <= '0;
            ma_last    <= '0;
            vrr        <= '0;
            wbuf       <= '0;
            wdata_last <= '0;
            wlo        <= '0;
            alo        <= '0;
        end else begin
            if (wr_lo && ((ar == AR_MAWR) || (ar == AR_MARR))) begin
                alo <= cpu_din;
            end
            if (wr_lo && (ar == AR_VDATA)) begin
                wlo <= cpu_din;
            end
            if (accept && trig_mawr) begin
                mawr <= ADDR_W'({cpu_din, alo});
            end else if (vram_we) begin
                mawr <= mawr + inc;
            end
            if (accept && trig_marr) begin
                marr <= ADDR_W'({cpu_din, alo});
            end else if (accept && trig_vrr) begin
                marr <= marr + inc;
            end
            if (accept && trig_vwr) begin
                wbuf <= {cpu_din, wlo};
            end
            if (vram_re || vram_we) begin
                ma_last <= vram_MA;
            end
            if (vram_we) begin
                wdata_last <= wbuf;
            end
            if (state == RD_WAIT) begin
                vrr <= vram_rdata;
            end
        end
    end

    assign cpu_dout = (ar == AR_VDATA) ? (cpu_hi ? vrr[15:8] : vrr[7:0]) : 8'h00;

endmodule

// File: tb/tb_vdc_vram_cpu_port.sv
// Directed bench for vdc_vram_cpu_port with a behavioural one-cycle-latency VRAM.
module tb_vdc_vram_cpu_port;

    logic        clock = 1'b0;
    logic        reset_N;
    logic [4:0]  ar;
    logic        cpu_wr, cpu_rd, cpu_hi;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [1:0]  incr_sel;
    logic        slot_grant;
    logic [15:0] vram_MA;
    logic        vram_re, vram_we;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata;
    logic        busy, overrun;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int rd_count = 0;
    int proto_err = 0;
    int snap;

    logic [15:0] mem [0:65535];

    vdc_vram_cpu_port #(.ADDR_W(16)) dut (
        .clock      (clock),
        .reset_N    (reset_N),
        .ar         (ar),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_hi     (cpu_hi),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .incr_sel   (incr_sel),
        .slot_grant (slot_grant),
        .vram_MA    (vram_MA),
        .vram_re    (vram_re),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (vram_we) begin
            mem[vram_MA] <= vram_wdata;
            wr_count <= wr_count + 1;
        end
        if (vram_re) begin
            vram_rdata <= mem[vram_MA];
            rd_count <= rd_count + 1;
        end
        if ((vram_re && vram_we) || ((vram_re || vram_we) && !slot_grant)) begin
            proto_err <= proto_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic hi, input logic [7:0] d);
        ar = a; cpu_hi = hi; cpu_din = d; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    // Loads VWR and strobes the high byte; returns one cycle into WR_PEND.
    task automatic vwr(input logic [7:0] lo, input logic [7:0] hi);
        reg_write(5'h02, 1'b0, lo);
        reg_write(5'h02, 1'b1, hi);
        #1;
    endtask

    initial begin
        reset_N = 1'b0;
        ar = 5'h02; cpu_wr = 0; cpu_rd = 0; cpu_hi = 0; cpu_din = 0;
        incr_sel = 2'b00; slot_grant = 1'b0; vram_rdata = 16'h0000;
        mem[16'h0040] = 16'hBEEF;
        mem[16'h0060] = 16'hCAFE;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_re", vram_re, 0);
        chk("rst_we", vram_we, 0);
        chk("rst_ma", vram_MA, 16'h0000);
        chk("rst_wdata", vram_wdata, 16'h0000);
        chk("rst_overrun", overrun, 0);
        chk("rst_dout", cpu_dout, 8'h00);
        #10 reset_N = 1'b1;
        tick();

        // basic write, +1
        slot_grant = 1'b1;
        reg_write(5'h00, 1'b0, 8'h34);
        reg_write(5'h00, 1'b1, 8'h12);
        reg_write(5'h02, 1'b0, 8'hCD);
        ar = 5'h02; cpu_hi = 1'b1; cpu_din = 8'hAB; cpu_wr = 1'b1;
        #1;
        chk("w1_busy_pre", busy, 0);
        chk("w1_ovr_pre", overrun, 0);
        tick();
        cpu_wr = 1'b0;
        #1;
        chk("w1_we", vram_we, 1);
        chk("w1_ma", vram_MA, 16'h1234);
        chk("w1_wdata", vram_wdata, 16'hABCD);
        chk("w1_busy", busy, 1);
        tick();
        chk("w1_busy_after", busy, 0);
        chk("w1_we_after", vram_we, 0);
        chk("w1_ma_hold", vram_MA, 16'h1234);
        chk("w1_mem", mem[16'h1234], 16'hABCD);
        vwr(8'h11, 8'h22);
        chk("w2_ma_incr", vram_MA, 16'h1235);
        chk("w2_we", vram_we, 1);
        tick();
        chk("w2_mem", mem[16'h1235], 16'h2211);

        // read path, +32
        incr_sel = 2'b01;
        reg_write(5'h01, 1'b0, 8'h40);
        reg_write(5'h01, 1'b1, 8'h00);
        #1;
        chk("r1_re", vram_re, 1);
        chk("r1_ma", vram_MA, 16'h0040);
        chk("r1_we", vram_we, 0);
        tick();
        chk("r1_busy_wait", busy, 1);
        chk("r1_re_wait", vram_re, 0);
        tick();
        chk("r1_busy_done", busy, 0);
        ar = 5'h02; cpu_hi = 1'b0; #1;
        chk("r1_vrr_lo", cpu_dout, 8'hEF);
        cpu_hi = 1'b1; cpu_rd = 1'b1; #1;
        chk("r2_dout_old_hi", cpu_dout, 8'hBE);
        tick();
        cpu_rd = 1'b0;
        #1;
        chk("r2_re", vram_re, 1);
        chk("r2_ma", vram_MA, 16'h0060);
        tick();
        tick();
        cpu_hi = 1'b1; #1;
        chk("r2_vrr_hi", cpu_dout, 8'hCA);
        cpu_hi = 1'b0; #1;
        chk("r2_vrr_lo", cpu_dout, 8'hFE);
        ar = 5'h00; #1;
        chk("dout_other_ar", cpu_dout, 8'h00);

        // slot stall and overrun, mawr now 1236
        slot_grant = 1'b0;
        incr_sel = 2'b00;
        snap = wr_count;
        vwr(8'h55, 8'h66);
        for (int i = 0; i < 5; i++) begin
            chk("stall_we", vram_we, 0);
            chk("stall_busy", busy, 1);
            tick();
        end
        ar = 5'h02; cpu_hi = 1'b1; cpu_din = 8'h77; cpu_wr = 1'b1;
        #1;
        chk("ovr_pulse", overrun, 1);
        tick();
        cpu_wr = 1'b0;
        #1;
        chk("ovr_clear", overrun, 0);
        chk("ovr_wbuf", vram_wdata, 16'h6655);
        slot_grant = 1'b1;
        #1;
        chk("stall_issue_we", vram_we, 1);
        chk("stall_issue_ma", vram_MA, 16'h1236);
        chk("stall_issue_wdata", vram_wdata, 16'h6655);
        tick();
        tick();
        tick();
        chk("stall_one_write", wr_count - snap, 1);
        chk("stall_mem", mem[16'h1236], 16'h6655);

        // wrap with +64
        incr_sel = 2'b10;
        reg_write(5'h00, 1'b0, 8'hC0);
        reg_write(5'h00, 1'b1, 8'hFF);
        vwr(8'h01, 8'h02);
        chk("wrap_ma0", vram_MA, 16'hFFC0);
        tick();
        vwr(8'h03, 8'h04);
        chk("wrap_ma1", vram_MA, 16'h0000);
        chk("wrap_we", vram_we, 1);
        tick();
        chk("wrap_mem", mem[16'h0000], 16'h0403);

        // async reset during RD_WAIT
        reg_write(5'h01, 1'b0, 8'h40);
        reg_write(5'h01, 1'b1, 8'h00);
        tick();
        chk("ar_busy_wait", busy, 1);
        snap = rd_count;
        #2 reset_N = 1'b0;
        #1;
        ar = 5'h02;
        cpu_hi = 1'b1; #1;
        chk("ar_busy", busy, 0);
        chk("ar_re", vram_re, 0);
        chk("ar_vrr_hi", cpu_dout, 8'h00);
        cpu_hi = 1'b0; #1;
        chk("ar_vrr_lo", cpu_dout, 8'h00);
        tick();
        tick();
        reset_N = 1'b1;
        tick();
        tick();
        tick();
        chk("ar_no_read", rd_count - snap, 0);
        chk("ar_idle", busy, 0);
        chk("protocol", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vdc_vram_cpu_port.md
Name: vdc_vram_cpu_port

Overview:
- CPU-side VRAM initiator inside the HuC6270 model; drives the VRAM responder's MA/re/we/MD_in and consumes MD_out.
- Implements the MAWR (write address), MARR (read address) and VWR/VRR (data) registers, with auto-increment and a one-word read-ahead buffer.
- Issues VRAM cycles only in slots granted by the renderer/slot arbiter, and reports busy to the CPU bus logic.

Parameters:
- ADDR_W, 16, VRAM word-address width; all address arithmetic wraps modulo 2**ADDR_W.

Ports:
- clock  in  1  system clock
- reset_N  in  1  asynchronous active-low reset
- ar  in  5  currently selected VDC register, latched upstream
- cpu_wr  in  1  one-cycle CPU byte-write strobe
- cpu_rd  in  1  one-cycle CPU byte-read strobe
- cpu_hi  in  1  0 = low byte ($0002), 1 = high byte ($0003)
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- incr_sel  in  2  CR[12:11]: 00→+1, 01→+32, 10→+64, 11→+128
- slot_grant  in  1  VRAM slot available to this port this cycle
- vram_MA  out  16  VRAM address
- vram_re  out  1  VRAM read enable
- vram_we  out  1  VRAM write enable
- vram_wdata  out  16  VRAM write data
- vram_rdata  in  16  VRAM read data, registered by VRAM one cycle after re
- busy  out  1  access pending or in flight
- overrun  out  1  one-cycle pulse: trigger dropped because busy

Behaviour:
- Reset (async, reset_N=0):
  - mawr, marr, vrr, wlo, alo = 0; state = IDLE.
  - All outputs 0: vram_re, vram_we, busy, overrun, vram_MA, vram_wdata.
  - A reset mid-access abandons the access; no VRAM cycle follows.
- States: IDLE, WR_PEND, RD_ISSUE, RD_WAIT. busy = (state != IDLE).
- Byte latching, always accepted (even when busy):
  - cpu_wr & ~cpu_hi & ar∈{0,1} → alo <= cpu_din.
  - cpu_wr & ~cpu_hi & ar==2 → wlo <= cpu_din.
- Triggers, accepted only in IDLE; if busy, drop the trigger, pulse overrun, and leave all registers unchanged:
  - cpu_wr & cpu_hi & ar==0 → mawr <= {cpu_din, alo}; no VRAM cycle.
  - cpu_wr & cpu_hi & ar==1 → marr <= {cpu_din, alo}; fetch address = {cpu_din, alo}; → RD_ISSUE.
  - cpu_wr & cpu_hi & ar==2 → wbuf <= {cpu_din, wlo}; → WR_PEND.
  - cpu_rd & cpu_hi & ar==2 → marr <= marr + inc; fetch address = marr + inc; → RD_ISSUE. cpu_dout returns the old vrr high byte in the same cycle.
- WR_PEND:
  - On a cycle with slot_grant=1: vram_we=1, vram_MA=mawr, vram_wdata=wbuf; mawr <= mawr + inc; → IDLE.
  - Otherwise wait indefinitely with vram_we=0.
- RD_ISSUE:
  - On a cycle with slot_grant=1: vram_re=1, vram_MA=marr; → RD_WAIT.
  - Otherwise wait.
- RD_WAIT: vrr <= vram_rdata at the next edge; → IDLE.
  - Read latency: vrr valid 2 edges after the granted re cycle.
- vram_re and vram_we are never high together, and are never high without slot_grant.
- vram_re, vram_we, vram_MA and vram_wdata are combinational from state/registers. vram_MA and vram_wdata hold their last value when idle.
- inc is 16-bit zero-extended. Example: 16'hFFFF + 1 → 16'h0000, 16'hFFC0 + 64 → 16'h0000.
- cpu_dout:
  - ar==2 → (cpu_hi ? vrr[15:8] : vrr[7:0]).
  - Otherwise 8'h00.
  - Combinational; valid regardless of cpu_rd.
- cpu_wr and cpu_rd high together: cpu_wr wins, cpu_rd is ignored.

Decomposition:
- Shared package huc6270_pkg:
  - Constants: AR_MAWR=5'h00, AR_MARR=5'h01, AR_VDATA=5'h02.
  - typedef enum port_state_t {IDLE, WR_PEND, RD_ISSUE, RD_WAIT}.
  - Function vdc_incr(logic [1:0]) returning 16-bit 1/32/64/128.
- No sub-module; a single module plus the package.

Test Plan:
- Write with incr_sel=00: write MAWR=16'h1234, VWR lo=8'hCD, hi=8'hAB, slot_grant=1 → one-cycle vram_we with MA=16'h1234, wdata=16'hABCD; mawr then 16'h1235; busy high exactly 1 cycle.
- Read path: VRAM[16'h0040]=16'hBEEF, [16'h0060]=16'hCAFE, incr_sel=01. Write MARR=16'h0040 → re at 0040, vrr=BEEF two edges later. Read VRR hi → cpu_dout=8'hBE same cycle; then re at MA=0060, vrr=CAFE.
- Slot stall: slot_grant=0 for 5 cycles after a VWR hi write → vram_we stays 0 and busy stays 1; the write issues in the first granted cycle.
- Overrun: with slot_grant=0, issue a second VWR hi write while in WR_PEND → overrun pulses 1 cycle, wbuf unchanged, and only the first write reaches VRAM.
- Wrap: mawr=16'hFFC0, incr_sel=10, one write → mawr=16'h0000.
- Async reset: assert reset_N=0 during RD_WAIT → busy, vram_re and vrr go to 0 immediately; no VRAM cycle after release.
